// File: rtl/segasys1_prgenc_pkg.sv
// Shared Sega System 1 crypt definitions: key-table download windows, the
// Type-2 bit-swap permutation set with its forward and inverse application,
// and the Type-1/Type-2 table index and candidate helpers.
// Imported by the encryptor top; the decryptor uses the same definitions.
package segasys1_prgenc_pkg;

  localparam logic [24:0] DEF_T1_BASE  = 25'h58400;
  localparam logic [24:0] DEF_T2X_BASE = 25'h48000;
  localparam logic [24:0] DEF_T2S_BASE = 25'h48080;

  // Type-1 leaves these plaintext bits untouched; bits 7/5/3 carry the key.
  localparam logic [7:0] T1_KEEP  = 8'h57;
  localparam logic [7:0] T1_FLIP  = 8'hA8;
  localparam logic [7:0] NUM_PERM = 8'd24;

  typedef enum logic [1:0] {
    ENC_PLAIN = 2'd0,
    ENC_T1    = 2'd1,
    ENC_T2    = 2'd2,
    ENC_RSVD  = 2'd3
  } enc_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_CHK  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Source bits {A,B,C,D} for destination bits {6,4,2,0}, one octal digit each.
  function automatic logic [11:0] perm(input logic [7:0] s);
    case (s)
      8'd0:    return 12'o6420;
      8'd1:    return 12'o4620;
      8'd2:    return 12'o2460;
      8'd3:    return 12'o0426;
      8'd4:    return 12'o6240;
      8'd5:    return 12'o6024;
      8'd6:    return 12'o6402;
      8'd7:    return 12'o2640;
      8'd8:    return 12'o4260;
      8'd9:    return 12'o4602;
      8'd10:   return 12'o6042;
      8'd11:   return 12'o0642;
      8'd12:   return 12'o4062;
      8'd13:   return 12'o0462;
      8'd14:   return 12'o6204;
      8'd15:   return 12'o2604;
      8'd16:   return 12'o0624;
      8'd17:   return 12'o2064;
      8'd18:   return 12'o0264;
      8'd19:   return 12'o4206;
      8'd20:   return 12'o2406;
      8'd21:   return 12'o4026;
      8'd22:   return 12'o2046;
      8'd23:   return 12'o0246;
      default: return 12'o6420;
    endcase
  endfunction

  // Forward swap as used by the decryptor: gathers even bits, odd bits pass.
  function automatic logic [7:0] bswp(input logic [7:0] s, input logic [7:0] v);
    logic [11:0] p;
    logic [7:0]  r;
    p    = perm(s);
    r    = v;
    r[6] = v[p[11:9]];
    r[4] = v[p[8:6]];
    r[2] = v[p[5:3]];
    r[0] = v[p[2:0]];
    return r;
  endfunction

  // Inverse swap: scatters the even bits back to where bswp gathered them.
  // The digits are a permutation of {6,4,2,0}, so every even bit is rewritten.
  function automatic logic [7:0] bswp_inv(input logic [7:0] s, input logic [7:0] y);
    logic [11:0] p;
    logic [7:0]  r;
    p          = perm(s);
    r          = y;
    r[p[11:9]] = y[6];
    r[p[8:6]]  = y[4];
    r[p[5:3]]  = y[2];
    r[p[2:0]]  = y[0];
    return r;
  endfunction

  function automatic logic [6:0] t2_index(input logic [15:0] a);
    return {a[14], a[12], a[9], a[6], a[3], a[0], ~a[15]};
  endfunction

  // k = {f, b5, b3}
  function automatic logic [6:0] t1_index(input logic [15:0] a, input logic [2:0] k);
    return {a[12], a[8], a[4], a[0], ~a[15], k[1] ^ k[2], k[0] ^ k[2]};
  endfunction

  function automatic logic [7:0] t1_cand(input logic [7:0] p, input logic [2:0] k);
    return (p & T1_KEEP) | {k[2], 1'b0, k[1], 1'b0, k[0], 3'b000};
  endfunction

  function automatic logic [7:0] t1_xorv(input logic f);
    return f ? T1_FLIP : 8'h00;
  endfunction

endpackage

// File: rtl/segasys1_keytbl.sv
// Purpose: 128x8 key table loaded from the download stream inside a 128-byte window.
// Latency: 1-cycle registered read; a write is visible to reads issued after its cycle.
// Backpressure: none; writes are always accepted.
// Ports: i_clk; i_dl_wr/i_dl_addr/i_dl_data download strobe, address, byte;
//        i_rd_idx read index; o_rd_data read data (one cycle after i_rd_idx).
module segasys1_keytbl #(
  parameter logic [24:0] BASE = 25'h0
) (
  input  logic        i_clk,
  input  logic        i_dl_wr,
  input  logic [24:0] i_dl_addr,
  input  logic [7:0]  i_dl_data,
  input  logic [6:0]  i_rd_idx,
  output logic [7:0]  o_rd_data
);

  logic [7:0] r_mem [128];
  logic [7:0] r_rd_data;
  logic       w_we;

  assign w_we      = i_dl_wr && (i_dl_addr[24:7] == BASE[24:7]);
  assign o_rd_data = r_rd_data;

  // Contents survive reset; only the download stream changes them.
  always_ff @(posedge i_clk) begin
    if (w_we) begin
      r_mem[i_dl_addr[6:0]] <= i_dl_data;
    end
    r_rd_data <= r_mem[i_rd_idx];
  end

endmodule

// File: rtl/segasys1_prgenc.sv
// Purpose: System 1 program-ROM encryptor, exact inverse of the opcode/data decryptor.
// Latency: plain 1 cycle, Type-2 3 cycles, Type-1 1+2*(k+1) cycles (17 worst case).
// Backpressure: req_ready only in IDLE; rsp_valid/rsp_data/rsp_err held until rsp_ready.
// Ports: clk, reset (sync, active-high); enc_type mode; dl_wr/dl_addr/dl_data table
//        download; req_valid/req_ready/req_m1/req_addr/req_data request;
//        rsp_valid/rsp_ready/rsp_data/rsp_err response.
module segasys1_prgenc
  import segasys1_prgenc_pkg::*;
#(
  parameter logic [24:0] T1_BASE  = DEF_T1_BASE,
  parameter logic [24:0] T2X_BASE = DEF_T2X_BASE,
  parameter logic [24:0] T2S_BASE = DEF_T2S_BASE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  enc_type,
  input  logic        dl_wr,
  input  logic [24:0] dl_addr,
  input  logic [7:0]  dl_data,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_m1,
  input  logic [14:0] req_addr,
  input  logic [7:0]  req_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [7:0]  rsp_data,
  output logic        rsp_err
);

  state_t     r_state;
  state_t     w_state_nxt;
  enc_t       r_type;
  enc_t       w_enc;
  logic [15:0] r_a;
  logic [7:0]  r_p;
  logic [2:0]  r_k;
  logic [7:0]  r_rsp_data;
  logic        r_rsp_err;

  logic        w_req_ready;
  logic        w_rsp_valid;
  logic        w_accept;
  logic        w_plain;
  logic [6:0]  w_t1_idx;
  logic [6:0]  w_t2_idx;
  logic [7:0]  w_t1_q;
  logic [7:0]  w_t2x_q;
  logic [7:0]  w_t2s_q;
  logic        w_t1_hit;
  logic        w_t2_bad;

  assign w_enc    = enc_t'(enc_type);
  assign w_plain  = (w_enc == ENC_PLAIN) || (w_enc == ENC_RSVD);
  assign w_accept = req_valid && w_req_ready;

  // Indices are driven from latched state in every cycle; only the value
  // read back during CHK matters, and it belongs to the index held in RD.
  assign w_t1_idx = t1_index(r_a, r_k);
  assign w_t2_idx = t2_index(r_a);

  segasys1_keytbl #(.BASE(T1_BASE)) u_t1 (
    .i_clk     (clk),
    .i_dl_wr   (dl_wr),
    .i_dl_addr (dl_addr),
    .i_dl_data (dl_data),
    .i_rd_idx  (w_t1_idx),
    .o_rd_data (w_t1_q)
  );

  segasys1_keytbl #(.BASE(T2X_BASE)) u_t2x (
    .i_clk     (clk),
    .i_dl_wr   (dl_wr),
    .i_dl_addr (dl_addr),
    .i_dl_data (dl_data),
    .i_rd_idx  (w_t2_idx),
    .o_rd_data (w_t2x_q)
  );

  segasys1_keytbl #(.BASE(T2S_BASE)) u_t2s (
    .i_clk     (clk),
    .i_dl_wr   (dl_wr),
    .i_dl_addr (dl_addr),
    .i_dl_data (dl_data),
    .i_rd_idx  (w_t2_idx),
    .o_rd_data (w_t2s_q)
  );

  // The candidate only differs from p in bits 7/5/3, so its masked part is
  // p & KEEP; the table term must then supply exactly the remaining bits.
  assign w_t1_hit = (((r_p & T1_KEEP) | (w_t1_q ^ t1_xorv(r_k[2]))) == r_p);
  assign w_t2_bad = (w_t2s_q >= NUM_PERM);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_req_ready = 1'b0;
    w_rsp_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_req_ready = 1'b1;
        if (req_valid) begin
          w_state_nxt = w_plain ? ST_DONE : ST_RD;
        end
      end
      ST_RD: begin
        w_state_nxt = ST_CHK;
      end
      ST_CHK: begin
        // Only a Type-1 miss with candidates left loops back for another read.
        if ((r_type == ENC_T1) && !w_t1_hit && (r_k != 3'd7)) begin
          w_state_nxt = ST_RD;
        end else begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        w_rsp_valid = 1'b1;
        if (rsp_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_type     <= ENC_PLAIN;
      r_a        <= '0;
      r_p        <= '0;
      r_k        <= '0;
      r_rsp_data <= '0;
      r_rsp_err  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_type <= w_enc;
        r_a    <= {req_m1, req_addr};
        r_p    <= req_data;
        r_k    <= '0;
        if (w_plain) begin
          r_rsp_data <= req_data;
          r_rsp_err  <= 1'b0;
        end
      end
      if (r_state == ST_CHK) begin
        if (r_type == ENC_T2) begin
          if (w_t2_bad) begin
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b1;
          end else begin
            r_rsp_data <= bswp_inv(w_t2s_q, r_p ^ w_t2x_q);
            r_rsp_err  <= 1'b0;
          end
        end else if (w_t1_hit) begin
          r_rsp_data <= t1_cand(r_p, r_k);
          r_rsp_err  <= 1'b0;
        end else if (r_k == 3'd7) begin
          r_rsp_data <= '0;
          r_rsp_err  <= 1'b1;
        end else begin
          r_k <= r_k + 3'd1;
        end
      end
    end
  end

  assign req_ready = w_req_ready;
  assign rsp_valid = w_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_err   = r_rsp_err;

endmodule
